mmio_responder: RTL and testbench
=================================

# mmio_responder

Answers every PSL MMIO request for the AFU. It sits directly downstream of the PSL MMIO port, consuming `MMIOInterfaceInput` and driving `MMIOInterfaceOutput`. Config-space reads return the AFU descriptor, and problem-space accesses target a small scratch register file plus a read-only status word. Each request is acknowledged exactly once, after a fixed latency, with odd parity on the returned data.

## Interface
Parameters:
- `AFU_REG_COUNT`, default 4: number of 64-bit scratch registers, range 1..64.
- `UNMAPPED_READ_VALUE`, default 64'hFFFF_FFFF_FFFF_FFFF: data returned for reads of unmapped addresses.

Ports:
- `clock`  in  1  sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `mmio_in`  in  `MMIOInterfaceInput`  PSL MMIO request.
- `descriptor`  in  `AFUDescriptor`  static AFU descriptor contents.
- `status_word`  in  64  live status (job running/done/error), sampled at decode.
- `mmio_out`  out  `MMIOInterfaceOutput`  ack, read data, data parity.
- `afu_regs`  out  `AFU_REG_COUNT`×64  current scratch register contents.
- `protocol_error`  out  1  sticky; a request arrived while busy.
- `parity_error`  out  1  sticky; inbound parity mismatch.

## Operation
- FSM states are IDLE, DECODE and ACK.
  - IDLE→DECODE when `mmio_in.valid` is high; the request fields are latched into a request register.
  - DECODE→ACK unconditionally.
  - ACK→DECODE if `valid` is high in that cycle, otherwise ACK→IDLE.
- Addressing: `address[0:22]` is the doubleword index (dw). `address[23]` selects the word: 0 selects bits [0:31], 1 selects bits [32:63].
- Config reads (`cfg=1`):
  - dw 0 returns {`num_ints_per_process`, `num_of_processes`, `num_of_afu_crs`, `req_prog_model`}.
  - Any other dw returns 0.
  - Config writes are acked and have no effect.
- Problem-space accesses (`cfg=0`):
  - dw 0..`AFU_REG_COUNT`-1 are read/write scratch registers.
  - dw `AFU_REG_COUNT` is `status_word`, read-only; writes to it are ignored.
  - Any other dw: reads return `UNMAPPED_READ_VALUE`, writes are ignored.
- 64-bit write (`doubleword=1`): the full register is written. `address[23]` must be 0; if it is 1, the write is ignored but still acked.
- 32-bit write: only the selected half is updated, using `data[32:63]`.
- 32-bit read: the selected word is replicated in both halves of `mmio_out.data`.
- Writes commit at the DECODE→ACK edge. A read in the very next request sees the new value.
- `mmio_out.data_parity` is always the odd parity of `mmio_out.data`.
- Busy overlap: `valid` seen while the FSM is in DECODE is dropped with no ack, and `protocol_error` is set. It clears only on reset.

## Timing
- A request with `valid` high in cycle T produces `mmio_out.ack` high for exactly one cycle, in cycle T+2, with data valid in that same cycle.
- Back-to-back requests: a new `valid` is accepted in the ACK cycle, giving a throughput of one request per 2 cycles.
- For write acks, `mmio_out.data` is 0 and its parity is 1.
- Reset values:
  - state IDLE.
  - `mmio_out.ack` 0, `mmio_out.data` 0, `mmio_out.data_parity` 1.
  - all `afu_regs` 0.
  - `protocol_error` 0, `parity_error` 0.
- Reset asserted mid-request drops the in-flight request. No ack is issued after reset release.

## Configuration
- `MMIO_PARITY_CHECK_EN` defined:
  - `address_parity` (all requests) and `data_parity` (writes) are checked for odd parity at DECODE.
  - On a mismatch, `parity_error` is set (sticky), the write is suppressed, and reads return `UNMAPPED_READ_VALUE`.
  - The ack is still issued at T+2.
- `MMIO_PARITY_CHECK_EN` undefined:
  - No inbound checks are made.
  - `parity_error` is tied to 0.
  - Output parity is still generated.

## Structure
- Shared CAPI package additions:
  - `mmio_state_t` enum (IDLE/DECODE/ACK).
  - `odd_parity64` function.
  - an `MMIO_STATUS_DW` offset helper.
  - a descriptor-doubleword read function that extends the existing descriptor read for dw 0.
- One sub-module, `mmio_reg_file`. It holds the scratch registers and takes a write enable, dw index, half-select and data, with combinational read.
- The FSM, decode and parity logic stay in `mmio_responder`.

## Test plan
- Config read, `address=0`, `doubleword=1`, descriptor fields {16'h0001,16'h0001,16'h0000,16'h8010} → ack at T+2 with data 64'h0001_0001_0000_8010 and correct odd parity.
- 64-bit write of 64'hDEAD_BEEF_0123_4567 to dw 1, then a 32-bit read at `address=3` → data 64'h0123_4567_0123_4567; `afu_regs[1]` matches.
- 32-bit write of 32'hCAFE_F00D at `address=0` (upper half of dw 0) → `afu_regs[0]` = 64'hCAFE_F00D_0000_0000.
- Read of dw 9 with `AFU_REG_COUNT=4` → all-ones; then a second `valid` one cycle after the first → `protocol_error`=1 and only one ack.
- With `MMIO_PARITY_CHECK_EN`, a write with flipped `data_parity` → `parity_error`=1, register unchanged, ack at T+2.
- Assert `rstn` low during DECODE → no ack, all outputs at reset values, and the next request is served normally.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
// Shared CAPI MMIO types and helpers. Fields are declared [W-1:0]; PSL big-endian bit b maps to [W-1-b].
package mmio_responder_pkg;

    localparam int unsigned MMIO_ADDR_W = 24;
    localparam int unsigned MMIO_DW_W   = 23;
    localparam int unsigned MMIO_DATA_W = 64;

    typedef struct packed {
        logic                   valid;
        logic                   read;
        logic                   doubleword;
        logic [MMIO_ADDR_W-1:0] address;
        logic                   address_parity;
        logic [MMIO_DATA_W-1:0] data;
        logic                   data_parity;
        logic                   cfg;
    } MMIOInterfaceInput;

    typedef struct packed {
        logic                   ack;
        logic [MMIO_DATA_W-1:0] data;
        logic                   data_parity;
    } MMIOInterfaceOutput;

    typedef struct packed {
        logic [15:0] num_ints_per_process;
        logic [15:0] num_of_processes;
        logic [15:0] num_of_afu_crs;
        logic [15:0] req_prog_model;
    } AFUDescriptor;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACK    = 2'd2
    } mmio_state_t;

    function automatic logic odd_parity64(input logic [63:0] d);
        return ~^d;
    endfunction

    // The status word sits immediately after the scratch registers.
    function automatic logic [MMIO_DW_W-1:0] mmio_status_dw(input int unsigned reg_count);
        return MMIO_DW_W'(reg_count);
    endfunction

    function automatic logic [63:0] afu_desc_dw0(input AFUDescriptor d);
        return {d.num_ints_per_process, d.num_of_processes, d.num_of_afu_crs, d.req_prog_model};
    endfunction

    function automatic logic [63:0] afu_desc_read_dw(input AFUDescriptor d,
                                                     input logic [MMIO_DW_W-1:0] dw);
        return (dw == '0) ? afu_desc_dw0(d) : 64'h0;
    endfunction

endpackage

// File: rtl/mmio_reg_file.sv
// Scratch register file: one write port with full/half select, combinational read.
module mmio_reg_file #(
    parameter int unsigned REG_COUNT = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      we,
    input  logic                      full,
    input  logic                      half_sel,
    input  logic [IDX_W-1:0]          idx,
    input  logic [63:0]               wdata,
    output logic [63:0]               rd_data,
    output logic [REG_COUNT-1:0][63:0] regs
);

    // half_sel 0 is the upper word; 32-bit writes always source wdata[31:0].
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            regs <= '0;
        end else if (we) begin
            if (full) begin
                regs[idx] <= wdata;
            end else if (half_sel) begin
                regs[idx][31:0] <= wdata[31:0];
            end else begin
                regs[idx][63:32] <= wdata[31:0];
            end
        end
    end

    assign rd_data = regs[idx];

endmodule

// File: rtl/mmio_responder.sv
// PSL MMIO responder: descriptor, scratch registers and status word, acked at T+2.
// Optional inbound parity checking via `MMIO_PARITY_CHECK_EN.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int unsigned AFU_REG_COUNT       = 4,
    parameter logic [63:0] UNMAPPED_READ_VALUE = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                           clock,
    input  logic                           rstn,
    input  MMIOInterfaceInput              mmio_in,
    input  AFUDescriptor                   descriptor,
    input  logic [63:0]                    status_word,
    output MMIOInterfaceOutput             mmio_out,
    output logic [AFU_REG_COUNT-1:0][63:0] afu_regs,
    output logic                           protocol_error,
    output logic                           parity_error
);

    localparam int unsigned IDX_W = (AFU_REG_COUNT > 1) ? $clog2(AFU_REG_COUNT) : 1;
    localparam logic [MMIO_DW_W-1:0] STATUS_DW = mmio_status_dw(AFU_REG_COUNT);

    mmio_state_t        state_q;
    mmio_state_t        state_next_c;
    logic               req_load_c;
    logic               overlap_c;
    MMIOInterfaceInput  req_q;
    MMIOInterfaceOutput out_q;
    logic               protocol_error_q;

    logic [MMIO_DW_W-1:0] dw_c;
    logic                 word_sel_c;
    logic [63:0]          rf_rd_c;
    logic                 rf_we_c;
    logic [63:0]          dw64_c;
    logic [31:0]          word_c;
    logic [63:0]          rd_data_c;
    logic                 parity_bad_c;

    assign dw_c       = req_q.address[MMIO_ADDR_W-1:1];
    assign word_sel_c = req_q.address[0];

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next_c;
        end
    end

    // Next state; a request is only accepted in IDLE or ACK.
    always_comb begin
        state_next_c = state_q;
        req_load_c   = 1'b0;
        overlap_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mmio_in.valid) begin
                    state_next_c = DECODE;
                    req_load_c   = 1'b1;
                end
            end
            DECODE: begin
                state_next_c = ACK;
                overlap_c    = mmio_in.valid;
            end
            ACK: begin
                if (mmio_in.valid) begin
                    state_next_c = DECODE;
                    req_load_c   = 1'b1;
                end else begin
                    state_next_c = IDLE;
                end
            end
            default: state_next_c = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            req_q <= '0;
        end else if (req_load_c) begin
            req_q <= mmio_in;
        end
    end

`ifdef MMIO_PARITY_CHECK_EN
    logic parity_error_q;

    always_comb begin
        parity_bad_c = ~(^{req_q.address, req_q.address_parity});
        if (!req_q.read && !(^{req_q.data, req_q.data_parity})) begin
            parity_bad_c = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            parity_error_q <= 1'b0;
        end else if (state_q == DECODE && parity_bad_c) begin
            parity_error_q <= 1'b1;
        end
    end

    assign parity_error = parity_error_q;

    logic unused_req_c;
    assign unused_req_c = req_q.valid;
`else
    assign parity_bad_c = 1'b0;
    assign parity_error = 1'b0;

    logic unused_req_c;
    assign unused_req_c = ^{req_q.valid, req_q.address_parity, req_q.data_parity};
`endif

    // Scratch writes: problem space, in range, not a 64-bit write to the odd word.
    assign rf_we_c = (state_q == DECODE) && !req_q.read && !req_q.cfg
                     && (dw_c < STATUS_DW) && !parity_bad_c
                     && !(req_q.doubleword && word_sel_c);

    mmio_reg_file #(
        .REG_COUNT (AFU_REG_COUNT),
        .IDX_W     (IDX_W)
    ) u_reg_file (
        .clock    (clock),
        .rstn     (rstn),
        .we       (rf_we_c),
        .full     (req_q.doubleword),
        .half_sel (word_sel_c),
        .idx      (dw_c[IDX_W-1:0]),
        .wdata    (req_q.data),
        .rd_data  (rf_rd_c),
        .regs     (afu_regs)
    );

    // Read data selection; 32-bit reads replicate the chosen word.
    always_comb begin
        dw64_c = UNMAPPED_READ_VALUE;
        if (req_q.cfg) begin
            dw64_c = afu_desc_read_dw(descriptor, dw_c);
        end else if (dw_c < STATUS_DW) begin
            dw64_c = rf_rd_c;
        end else if (dw_c == STATUS_DW) begin
            dw64_c = status_word;
        end
        if (parity_bad_c) begin
            dw64_c = UNMAPPED_READ_VALUE;
        end
        word_c    = word_sel_c ? dw64_c[31:0] : dw64_c[63:32];
        rd_data_c = req_q.doubleword ? dw64_c : {word_c, word_c};
        if (!req_q.read) begin
            rd_data_c = '0;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            out_q.ack         <= 1'b0;
            out_q.data        <= '0;
            out_q.data_parity <= 1'b1;
        end else begin
            out_q.ack <= (state_q == DECODE);
            if (state_q == DECODE) begin
                out_q.data        <= rd_data_c;
                out_q.data_parity <= odd_parity64(rd_data_c);
            end
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            protocol_error_q <= 1'b0;
        end else if (overlap_c) begin
            protocol_error_q <= 1'b1;
        end
    end

    assign mmio_out       = out_q;
    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with hand-computed expected values.
module tb_mmio_responder;
    import mmio_responder_pkg::*;

    logic               clock = 1'b0;
    logic               rstn;
    MMIOInterfaceInput  mmio_in;
    AFUDescriptor       descriptor;
    logic [63:0]        status_word;
    MMIOInterfaceOutput mmio_out;
    logic [3:0][63:0]   afu_regs;
    logic               protocol_error;
    logic               parity_error;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    mmio_responder dut (
        .clock          (clock),
        .rstn           (rstn),
        .mmio_in        (mmio_in),
        .descriptor     (descriptor),
        .status_word    (status_word),
        .mmio_out       (mmio_out),
        .afu_regs       (afu_regs),
        .protocol_error (protocol_error),
        .parity_error   (parity_error)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic dbl, input logic cfg,
                         input logic [23:0] addr, input logic [63:0] data, input logic flip);
        mmio_in.valid          = 1'b1;
        mmio_in.read           = rd;
        mmio_in.doubleword     = dbl;
        mmio_in.cfg            = cfg;
        mmio_in.address        = addr;
        mmio_in.address_parity = ~^addr;
        mmio_in.data           = data;
        mmio_in.data_parity    = (~^data) ^ flip;
    endtask

    // One isolated request: no ack at T+1, ack with data at T+2, gone at T+3.
    task automatic transact(input string tag, input logic rd, input logic dbl, input logic cfg,
                            input logic [23:0] addr, input logic [63:0] data,
                            input logic [63:0] exp_data, input logic exp_par);
        issue(rd, dbl, cfg, addr, data, 1'b0);
        tick();
        mmio_in.valid = 1'b0;
        chk1({tag, "_ack_t1"}, mmio_out.ack, 1'b0);
        tick();
        chk1({tag, "_ack_t2"}, mmio_out.ack, 1'b1);
        chk64({tag, "_data"}, mmio_out.data, exp_data);
        chk1({tag, "_par"}, mmio_out.data_parity, exp_par);
        tick();
        chk1({tag, "_ack_t3"}, mmio_out.ack, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk1({tag, "_ack"}, mmio_out.ack, 1'b0);
        chk64({tag, "_data"}, mmio_out.data, 64'h0);
        chk1({tag, "_par"}, mmio_out.data_parity, 1'b1);
        chk1({tag, "_perr"}, protocol_error, 1'b0);
        chk1({tag, "_parerr"}, parity_error, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk64($sformatf("%s_reg%0d", tag, i), afu_regs[i], 64'h0);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        mmio_in     = '0;
        descriptor  = '{16'h0001, 16'h0001, 16'h0000, 16'h8010};
        status_word = 64'h0000_0000_0000_0007;
        tick();
        chk_reset_state("reset");
        tick();
        rstn = 1'b1;
        tick();

        // Config space
        transact("cfg_dw0", 1'b1, 1'b1, 1'b1, 24'd0, 64'h0, 64'h0001_0001_0000_8010, 1'b1);
        transact("cfg_dw0_lo32", 1'b1, 1'b0, 1'b1, 24'd1, 64'h0, 64'h0000_8010_0000_8010, 1'b1);
        transact("cfg_dw1", 1'b1, 1'b1, 1'b1, 24'd2, 64'h0, 64'h0, 1'b1);

        // Scratch registers
        transact("wr64_dw1", 1'b0, 1'b1, 1'b0, 24'd2, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b1);
        chk64("reg1_after_wr64", afu_regs[1], 64'hDEAD_BEEF_0123_4567);
        transact("rd32_addr3", 1'b1, 1'b0, 1'b0, 24'd3, 64'h0, 64'h0123_4567_0123_4567, 1'b1);
        transact("rd32_addr2", 1'b1, 1'b0, 1'b0, 24'd2, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        transact("wr32_hi_dw0", 1'b0, 1'b0, 1'b0, 24'd0, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b1);
        chk64("reg0_after_wr32_hi", afu_regs[0], 64'hCAFE_F00D_0000_0000);
        transact("wr32_lo_dw0", 1'b0, 1'b0, 1'b0, 24'd1, 64'h0000_0000_1234_5678, 64'h0, 1'b1);
        chk64("reg0_after_wr32_lo", afu_regs[0], 64'hCAFE_F00D_1234_5678);
        transact("wr64_odd_word", 1'b0, 1'b1, 1'b0, 24'd3, 64'h1111_1111_1111_1111, 64'h0, 1'b1);
        chk64("reg1_unchanged", afu_regs[1], 64'hDEAD_BEEF_0123_4567);
        transact("cfg_wr", 1'b0, 1'b1, 1'b1, 24'd0, 64'h2222_2222_2222_2222, 64'h0, 1'b1);
        chk64("reg0_after_cfg_wr", afu_regs[0], 64'hCAFE_F00D_1234_5678);

        // Status word: read-only
        transact("rd_status", 1'b1, 1'b1, 1'b0, 24'd8, 64'h0, 64'h0000_0000_0000_0007, 1'b0);
        transact("wr_status", 1'b0, 1'b1, 1'b0, 24'd8, 64'h3333_3333_3333_3333, 64'h0, 1'b1);
        chk64("reg0_after_status_wr", afu_regs[0], 64'hCAFE_F00D_1234_5678);
        chk64("reg1_after_status_wr", afu_regs[1], 64'hDEAD_BEEF_0123_4567);
        chk64("reg2_after_status_wr", afu_regs[2], 64'h0);
        chk64("reg3_after_status_wr", afu_regs[3], 64'h0);

        // Back-to-back: write in T, read of same dw accepted in the ACK cycle T+2
        issue(1'b0, 1'b1, 1'b0, 24'd4, 64'hA5A5_A5A5_0000_0001, 1'b0);
        tick();
        mmio_in.valid = 1'b0;
        chk1("b2b_wr_ack_t1", mmio_out.ack, 1'b0);
        tick();
        chk1("b2b_wr_ack_t2", mmio_out.ack, 1'b1);
        chk64("b2b_wr_data", mmio_out.data, 64'h0);
        issue(1'b1, 1'b1, 1'b0, 24'd4, 64'h0, 1'b0);
        tick();
        mmio_in.valid = 1'b0;
        chk1("b2b_rd_ack_t3", mmio_out.ack, 1'b0);
        tick();
        chk1("b2b_rd_ack_t4", mmio_out.ack, 1'b1);
        chk64("b2b_rd_data", mmio_out.data, 64'hA5A5_A5A5_0000_0001);
        chk1("b2b_rd_par", mmio_out.data_parity, 1'b0);
        tick();
        chk1("b2b_ack_gone", mmio_out.ack, 1'b0);
        chk64("reg2_after_b2b", afu_regs[2], 64'hA5A5_A5A5_0000_0001);

        // Unmapped read with an overlapping request in DECODE
        chk1("perr_before_overlap", protocol_error, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 24'd18, 64'h0, 1'b0);
        tick();
        issue(1'b1, 1'b1, 1'b1, 24'd0, 64'h0, 1'b0);
        tick();
        mmio_in.valid = 1'b0;
        chk1("unmapped_ack", mmio_out.ack, 1'b1);
        chk64("unmapped_data", mmio_out.data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk1("unmapped_par", mmio_out.data_parity, 1'b1);
        chk1("overlap_perr", protocol_error, 1'b1);
        tick();
        chk1("overlap_no_ack_t3", mmio_out.ack, 1'b0);
        tick();
        chk1("overlap_no_ack_t4", mmio_out.ack, 1'b0);
        chk1("overlap_perr_sticky", protocol_error, 1'b1);

`ifdef MMIO_PARITY_CHECK_EN
        issue(1'b0, 1'b1, 1'b0, 24'd6, 64'h0000_0000_0000_0055, 1'b1);
        tick();
        mmio_in.valid = 1'b0;
        chk1("parbad_ack_t1", mmio_out.ack, 1'b0);
        tick();
        chk1("parbad_ack_t2", mmio_out.ack, 1'b1);
        chk64("parbad_data", mmio_out.data, 64'h0);
        chk1("parbad_flag", parity_error, 1'b1);
        chk64("parbad_reg3", afu_regs[3], 64'h0);
        tick();
`else
        chk1("parity_error_tied", parity_error, 1'b0);
`endif

        // Reset during DECODE drops the request
        issue(1'b1, 1'b1, 1'b1, 24'd0, 64'h0, 1'b0);
        tick();
        mmio_in.valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        tick();
        rstn = 1'b1;
        tick();
        chk1("post_reset_no_ack1", mmio_out.ack, 1'b0);
        tick();
        chk1("post_reset_no_ack2", mmio_out.ack, 1'b0);
        transact("post_reset_cfg", 1'b1, 1'b1, 1'b1, 24'd0, 64'h0, 64'h0001_0001_0000_8010, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
